// File: rtl/vpu_pkg.sv
// Shared VPU widths used by the FP execution units and their source/destination ports.
package vpu_pkg;
  localparam int OPERAND_WIDTH  = 32;
  localparam int DST_ADDR_WIDTH = 5;
endpackage

// File: rtl/sal_fifo.sv
// Power-of-two synchronous FIFO. The caller guarantees push only when not full
// or popping in the same cycle, and pop only when not empty.
module sal_fifo #(
  parameter int DEPTH_LG2  = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int DEPTH = 1 << DEPTH_LG2;

  logic [DEPTH_LG2:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LG2:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LG2] != rd_ptr_q[DEPTH_LG2]) &&
                   (wr_ptr_q[DEPTH_LG2-1:0] == rd_ptr_q[DEPTH_LG2-1:0]);
  assign data_o  = mem_q[rd_ptr_q[DEPTH_LG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_i) begin
      mem_d[wr_ptr_q[DEPTH_LG2-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/vpu_dst_port.sv
// Destination collector for the FP adder: pairs issued addresses with in-order
// results and hands them to register-file writeback, returning issue credits.
module vpu_dst_port
  import vpu_pkg::*;
#(
  parameter int ACCEPTANCE_CAPABILITY = 2,
  parameter int ADDR_WIDTH            = DST_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_i,
  input  logic [ADDR_WIDTH-1:0]    issue_addr_i,
  output logic                     issue_ready_o,
  input  logic [OPERAND_WIDTH-1:0] result_i,
  input  logic                     done_i,
  output logic                     wb_valid_o,
  output logic [ADDR_WIDTH-1:0]    wb_addr_o,
  output logic [OPERAND_WIDTH-1:0] wb_data_o,
  input  logic                     wb_ready_i,
  output logic                     err_o
);
  localparam int CNT_W     = $clog2(ACCEPTANCE_CAPABILITY + 1);
  localparam int DEPTH_LG2 = $clog2(ACCEPTANCE_CAPABILITY);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(ACCEPTANCE_CAPABILITY);

  // Valid/ready: a writeback transfers on a rising edge where wb_valid_o and
  // wb_ready_i are both high; address/data stay frozen while valid waits.

  logic [CNT_W-1:0]         credit_q, credit_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;
  logic                     err_q, err_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [ADDR_WIDTH-1:0]    wb_addr_q, wb_addr_d;
  logic [OPERAND_WIDTH-1:0] wb_data_q, wb_data_d;

  logic                     addr_full, addr_empty, res_full, res_empty;
  logic [ADDR_WIDTH-1:0]    addr_head;
  logic [OPERAND_WIDTH-1:0] res_head;
  logic issue_acc, wb_hs, done_ok, load, bypass, addr_pop, res_pop, res_push;

  always_comb begin
    issue_acc = issue_i & issue_ready_o;
    wb_hs     = wb_valid_q & wb_ready_i;
    done_ok   = done_i & (outstanding_q != '0);
    // A result arriving into an empty result queue goes straight to the output
    // register so writeback follows done_i by one cycle.
    load      = !addr_empty & (!res_empty | done_ok) & (!wb_valid_q | wb_ready_i);
    bypass    = load & res_empty;
    addr_pop  = load;
    res_pop   = load & !res_empty;
    res_push  = done_ok & !bypass & (!res_full | res_pop);

    credit_d = credit_q;
    case ({issue_acc, wb_hs})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase

    outstanding_d = outstanding_q;
    case ({issue_acc, done_ok})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    err_d = err_q | (issue_i & !issue_ready_o) | (done_i & !(bypass | res_push));

    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (load) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = addr_head;
      wb_data_d  = res_empty ? result_i : res_head;
    end else if (wb_hs) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q      <= CREDIT_MAX;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
    end else begin
      credit_q      <= credit_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign issue_ready_o = (credit_q != '0);
  assign wb_valid_o    = wb_valid_q;
  assign wb_addr_o     = wb_addr_q;
  assign wb_data_o     = wb_data_q;
  assign err_o         = err_q;

  sal_fifo #(.DEPTH_LG2(DEPTH_LG2), .DATA_WIDTH(ADDR_WIDTH)) u_addr_q (
    .clk(clk), .rst_n(rst_n), .push_i(issue_acc), .data_i(issue_addr_i),
    .pop_i(addr_pop), .data_o(addr_head), .full_o(addr_full), .empty_o(addr_empty)
  );

  sal_fifo #(.DEPTH_LG2(DEPTH_LG2), .DATA_WIDTH(OPERAND_WIDTH)) u_res_q (
    .clk(clk), .rst_n(rst_n), .push_i(res_push), .data_i(result_i),
    .pop_i(res_pop), .data_o(res_head), .full_o(res_full), .empty_o(res_empty)
  );

  // Credits keep the address queue from overflowing; its full flag is informational.
  logic unused_addr_full;
  assign unused_addr_full = addr_full;
endmodule

// File: tb/tb_vpu_dst_port.sv
// Bench for vpu_dst_port: directed scenarios plus random traffic, all checked
// against a transaction-level model and an expected writeback queue.
module tb_vpu_dst_port;
  import vpu_pkg::*;

  localparam int CAP = 2;
  localparam int AW  = DST_ADDR_WIDTH;
  localparam int DW  = OPERAND_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_i = 1'b0;
  logic [AW-1:0] issue_addr_i = '0;
  logic          issue_ready_o;
  logic [DW-1:0] result_i = '0;
  logic          done_i = 1'b0;
  logic          wb_valid_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic          wb_ready_i = 1'b0;
  logic          err_o;

  vpu_dst_port #(.ACCEPTANCE_CAPABILITY(CAP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .issue_addr_i(issue_addr_i),
    .issue_ready_o(issue_ready_o), .result_i(result_i), .done_i(done_i),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: credits = CAP minus ops issued but not yet written back;
  // pending = issued ops still waiting for their result.
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    pend_addr_q[$];
  int               m_credit = CAP;
  logic             m_err = 1'b0;
  logic             hold_v = 1'b0;
  logic [AW-1:0]    hold_a = '0;
  logic [DW-1:0]    hold_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model, evaluated mid-cycle: checks the current outputs, then
  // advances the model by what the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_addr_q.delete();
      m_credit = CAP;
      m_err    = 1'b0;
      hold_v   = 1'b0;
    end else begin
      logic [AW+DW-1:0] e;
      logic hs, iacc;
      check("issue_ready_o", 64'(issue_ready_o), 64'(m_credit != 0));
      check("credit", 64'(dut.credit_q), 64'(m_credit));
      check("err_o", 64'(err_o), 64'(m_err));
      if (hold_v) begin
        check("hold_valid", 64'(wb_valid_o), 64'(1));
        check("hold_addr", 64'(wb_addr_o), 64'(hold_a));
        check("hold_data", 64'(wb_data_o), 64'(hold_d));
      end
      hs = wb_valid_o & wb_ready_i;
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wb_unexpected: got addr %0h data %0h expected no writeback", wb_addr_o, wb_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 64'(wb_addr_o), 64'(e[AW+DW-1:DW]));
          check("wb_data", 64'(wb_data_o), 64'(e[DW-1:0]));
        end
      end
      hold_v = wb_valid_o & !wb_ready_i;
      hold_a = wb_addr_o;
      hold_d = wb_data_o;

      iacc = issue_i && (m_credit != 0);
      if (issue_i && !iacc) m_err = 1'b1;
      if (done_i) begin
        if (pend_addr_q.size() == 0) m_err = 1'b1;
        else exp_q.push_back({pend_addr_q.pop_front(), result_i});
      end
      if (iacc) pend_addr_q.push_back(issue_addr_i);
      m_credit = m_credit - int'(iacc) + int'(hs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [AW-1:0] a);
    issue_i = 1'b1;
    issue_addr_i = a;
    tick();
    issue_i = 1'b0;
  endtask

  task automatic do_done(input logic [DW-1:0] r);
    done_i = 1'b1;
    result_i = r;
    tick();
    done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_i = 1'b0;
    done_i = 1'b0;
    wb_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int drain;
    // Reset values
    do_reset();
    check("rst_wb_valid", 64'(wb_valid_o), 64'(0));
    check("rst_wb_addr", 64'(wb_addr_o), 64'(0));
    check("rst_wb_data", 64'(wb_data_o), 64'(0));
    check("rst_issue_ready", 64'(issue_ready_o), 64'(1));
    check("rst_err", 64'(err_o), 64'(0));

    // Single op: writeback visible the cycle after done_i
    wb_ready_i = 1'b1;
    do_issue(5);
    repeat (3) tick();
    do_done(32'h3F80_0000);
    check("single_valid", 64'(wb_valid_o), 64'(1));
    check("single_addr", 64'(wb_addr_o), 64'(5));
    check("single_data", 64'(wb_data_o), 64'h3F80_0000);
    tick();
    check("single_credit_back", 64'(issue_ready_o), 64'(1));
    check("single_drained", 64'(wb_valid_o), 64'(0));

    // Credit exhaustion, then an illegal issue
    do_reset();
    do_issue(1);
    do_issue(2);
    check("exhaust_ready", 64'(issue_ready_o), 64'(0));
    do_issue(3);
    check("exhaust_err", 64'(err_o), 64'(1));

    // Backpressure: pair held, second queued, then back-to-back drain
    do_done(32'h1111_0001);
    do_done(32'h2222_0002);
    repeat (6) tick();
    check("bp_valid", 64'(wb_valid_o), 64'(1));
    check("bp_addr", 64'(wb_addr_o), 64'(1));
    wb_ready_i = 1'b1;
    tick();
    check("bp_second_valid", 64'(wb_valid_o), 64'(1));
    check("bp_second_addr", 64'(wb_addr_o), 64'(2));
    check("bp_second_data", 64'(wb_data_o), 64'h2222_0002);
    tick();
    check("bp_empty", 64'(wb_valid_o), 64'(0));

    // Issue and writeback handshake in the same cycle with one credit left
    do_reset();
    do_issue(3);
    do_done(32'hABCD_0003);
    tick();
    issue_i = 1'b1;
    issue_addr_i = 7;
    wb_ready_i = 1'b1;
    tick();
    issue_i = 1'b0;
    wb_ready_i = 1'b0;
    check("simul_credit", 64'(dut.credit_q), 64'(1));
    check("simul_err", 64'(err_o), 64'(0));

    // Spurious done right after reset
    do_reset();
    wb_ready_i = 1'b1;
    do_done(32'hDEAD_BEEF);
    check("spurious_err", 64'(err_o), 64'(1));
    check("spurious_valid", 64'(wb_valid_o), 64'(0));
    tick();
    check("spurious_valid_later", 64'(wb_valid_o), 64'(0));

    // Asynchronous reset while a writeback is pending and one more is queued
    do_reset();
    do_issue(9);
    do_issue(10);
    do_done(32'h0000_0009);
    do_done(32'h0000_000A);
    check("mid_valid_before", 64'(wb_valid_o), 64'(1));
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(wb_valid_o), 64'(0));
    check("mid_rst_addr", 64'(wb_addr_o), 64'(0));
    check("mid_rst_data", 64'(wb_data_o), 64'(0));
    check("mid_rst_ready", 64'(issue_ready_o), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("mid_credit_full", 64'(dut.credit_q), 64'(CAP));

    // Random legal traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      issue_i      = (m_credit != 0) && ($urandom_range(0, 1) == 1);
      issue_addr_i = AW'($urandom_range(0, (1 << AW) - 1));
      done_i       = (pend_addr_q.size() != 0) && ($urandom_range(0, 2) != 0);
      result_i     = DW'($urandom);
      wb_ready_i   = ($urandom_range(0, 9) < 7);
      tick();
    end
    issue_i = 1'b0;
    wb_ready_i = 1'b1;
    drain = 0;
    while ((pend_addr_q.size() != 0 || exp_q.size() != 0) && drain < 50) begin
      done_i   = (pend_addr_q.size() != 0);
      result_i = DW'($urandom);
      tick();
      drain++;
    end
    done_i = 1'b0;
    repeat (2) tick();
    check("drain_exp_empty", 64'(exp_q.size()), 64'(0));
    check("drain_valid", 64'(wb_valid_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vpu_dst_port.md
# vpu_dst_port

Destination-side collector for the VPU FP execution units. Sits directly downstream of the three-operand FP adder: it records each issued operation's destination address, captures the result on the unit's `done` pulse, and presents ordered address/data pairs to register-file writeback over a valid/ready handshake. The execution unit cannot stall, so the block also returns issue credits to the source port, which guarantees a result is never produced without buffer space.

## Interface
- `ACCEPTANCE_CAPABILITY`, 2: maximum operations in flight plus buffered; power of two, ≥2.
- `ADDR_WIDTH`, 5: destination register address width.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `issue_i` in 1: source port starts an operation this cycle; same pulse as the FP unit's `start_i`.
- `issue_addr_i` in `ADDR_WIDTH`: destination address of the issued operation.
- `issue_ready_o` out 1: at least one credit available; the source may only assert `issue_i` when this is high.
- `result_i` in `VPU_PKG::OPERAND_WIDTH`: FP unit result.
- `done_i` in 1: `result_i` is valid this cycle; single-cycle pulse; no backpressure.
- `wb_valid_o` out 1: writeback request.
- `wb_addr_o` out `ADDR_WIDTH`: writeback address.
- `wb_data_o` out `VPU_PKG::OPERAND_WIDTH`: writeback data.
- `wb_ready_i` in 1: register file accepts the request.
- `err_o` out 1: sticky protocol-error flag; cleared only by reset.

## Operation
- **Credit counter**
  - Width is `$clog2(ACCEPTANCE_CAPABILITY+1)`; reset value is `ACCEPTANCE_CAPABILITY`.
  - Decrements on an accepted issue (`issue_i & issue_ready_o`).
  - Increments on a writeback handshake (`wb_valid_o & wb_ready_i`).
  - Both in the same cycle: unchanged.
  - `issue_ready_o = (credit != 0)`.
- **Address queue:** FIFO of depth `ACCEPTANCE_CAPABILITY`, pushed on every accepted issue.
- **Result queue:** FIFO of depth `ACCEPTANCE_CAPABILITY`, pushed on `done_i`.
- **Ordering:** the FP unit completes in order, so the queue heads pair 1:1.
- **Output register:** a single stage holding `wb_valid_o`/`wb_addr_o`/`wb_data_o`.
  - Loads when both queues are non-empty and the register is empty or being drained this cycle (`wb_valid_o & wb_ready_i`).
  - `wb_addr_o`/`wb_data_o` are stable while `wb_valid_o & !wb_ready_i`.
- **Errors:** `err_o` sets and stays set on any of the following:
  - `issue_i` while `issue_ready_o` is 0. The issue is ignored: no push, no credit change.
  - `done_i` while the result queue is full. The result is dropped.
  - `done_i` with no outstanding issued-but-uncompleted operation. The result is dropped.
- **Outstanding counter:** internal; incremented on accepted issue, decremented on accepted `done_i`.

## Timing
- **Reset values:** `issue_ready_o`=1, `wb_valid_o`=0, `wb_addr_o`=0, `wb_data_o`=0, `err_o`=0. Credits are full, both queues are empty, outstanding is 0.
- **Latency:** `done_i` at cycle t with `wb_ready_i` high and nothing older pending gives `wb_valid_o` at t+1.
- **Throughput:** one writeback per cycle when `wb_ready_i` is held high.
- **Credit return:** a writeback handshake at cycle t raises `issue_ready_o` at t+1 if credit was 0.
- **Simultaneous issue + done + writeback:** all three take effect; counters net correctly.
- **Full/empty:** a queue pops in the same cycle it is full and pushes without loss. An empty queue never drives the output register.
- **Reset mid-operation:** all in-flight and buffered entries are discarded, credits return to full, and `wb_valid_o` drops immediately (asynchronous reset).

## Structure
- Add `VPU_PKG::DST_ADDR_WIDTH` (=5) as the default for `ADDR_WIDTH`; reuse `VPU_PKG::OPERAND_WIDTH`.
- Sub-module: `SAL_FIFO`, instantiated twice.
  - `DEPTH_LG2 = $clog2(ACCEPTANCE_CAPABILITY)`.
  - Address queue: `DATA_WIDTH = ADDR_WIDTH`.
  - Result queue: `DATA_WIDTH = OPERAND_WIDTH`.
- Credit and outstanding counters, output register and error logic live in this module.

## Test plan
- **Single op:** issue addr 5, then `done_i` with 0x3F800000 four cycles later, `wb_ready_i`=1 → `wb_valid_o` one cycle after `done_i` with addr 5 / data 0x3F800000; credit returns to 2.
- **Credit exhaustion:** two issues (addr 1, 2) with no `done_i` → `issue_ready_o`=0. A third `issue_i` → `err_o`=1 and no state change.
- **Backpressure:** two results with `wb_ready_i`=0 for 6 cycles → the first pair holds stable and the second stays queued. On releasing `wb_ready_i`, writebacks for addr 1 then addr 2 occur in consecutive cycles.
- **Simultaneous events:** with credit=1, issue addr 7 in the same cycle as a writeback handshake → credit stays 1 and no error is flagged.
- **Spurious done:** `done_i` right after reset → `err_o`=1 and `wb_valid_o` stays 0.
- **Reset mid-operation:** assert `rst_n`=0 while `wb_valid_o`=1 with one op queued → outputs return to reset values asynchronously and credit is 2 after release.
